// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 64-bit word UART receiver.
package uart_rx_pkg;

  localparam logic [7:0] LF_CHAR = 8'h0A;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_t;

  typedef enum logic [1:0] {
    WORD_COLLECT,
    WORD_WAIT_LF,
    WORD_RESYNC
  } word_state_t;

  // Cycles from start-bit edge to the start-bit mid-point resample.
  function automatic int unsigned half_bit_cycles(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Word handshake bus between the receiver (master) and the write/command logic (slave).
interface uart_rx_word_if #(
  parameter int unsigned WORD_BYTES = 8
);
  localparam int unsigned DATA_W = 8 * WORD_BYTES;

  logic [DATA_W-1:0] wrdata;
  logic              wrvalid;
  logic              wrack;

  modport master (output wrdata, output wrvalid, input wrack);
  modport slave  (input wrdata, input wrvalid, output wrack);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rxd synchronizer, bit FSM, byte strobe and framing error.
module uart_rx_byte
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       uartclk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rxbyte,
  output logic       rxstb,
  output logic       frmerr,
  output logic       rxbusy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_cycles(CLKS_PER_BIT) - 1);

  logic rxd_meta, rxd_s, rxd_d;

  bit_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             frm_hold, frm_hold_nxt;
  logic [7:0]       rxbyte_nxt;
  logic             rxstb_nxt, frmerr_nxt, rxbusy_nxt;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge uartclk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_d    <= rxd_s;
    end
  end

  // Bit FSM state and registered outputs.
  always_ff @(posedge uartclk or posedge rst) begin
    if (rst) begin
      state    <= BIT_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      frm_hold <= 1'b0;
      rxbyte   <= '0;
      rxstb    <= 1'b0;
      frmerr   <= 1'b0;
      rxbusy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      frm_hold <= frm_hold_nxt;
      rxbyte   <= rxbyte_nxt;
      rxstb    <= rxstb_nxt;
      frmerr   <= frmerr_nxt;
      rxbusy   <= rxbusy_nxt;
    end
  end

  // Next-state: start detect, mid-bit sampling, stop check; a framing error holds in STOP until rxd idles high.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    frm_hold_nxt = frm_hold;
    rxbyte_nxt   = rxbyte;
    rxstb_nxt    = 1'b0;
    frmerr_nxt   = 1'b0;
    rxbusy_nxt   = rxbusy;
    case (state)
      BIT_IDLE: begin
        if (rxd_d && !rxd_s) begin
          state_nxt  = BIT_START;
          cnt_nxt    = '0;
          rxbusy_nxt = 1'b1;
        end
      end
      BIT_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rxd_s) begin
            state_nxt   = BIT_DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt  = BIT_IDLE;
            rxbusy_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BIT_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rxd_s, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = BIT_STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BIT_STOP: begin
        if (frm_hold) begin
          if (rxd_s) begin
            frm_hold_nxt = 1'b0;
            state_nxt    = BIT_IDLE;
          end
        end else if (cnt == BIT_LAST) begin
          cnt_nxt    = '0;
          rxbusy_nxt = 1'b0;
          if (rxd_s) begin
            rxbyte_nxt = shreg;
            rxstb_nxt  = 1'b1;
            state_nxt  = BIT_IDLE;
          end else begin
            frmerr_nxt   = 1'b1;
            frm_hold_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = BIT_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: LF-terminated 8-byte words, MSB byte first, presented with valid/ack.
// Optional inter-byte timeout enabled by defining RXWORD_TIMEOUT_EN.
module uart_rx_word
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned WORD_BYTES   = 8,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic           uartclk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_word_if.master wr,
  output logic           rxbusy,
  output logic           rxerr
);

  localparam int unsigned DATA_W = 8 * WORD_BYTES;
  localparam int unsigned BCNT_W = $clog2(WORD_BYTES + 1);

  logic [7:0] rxbyte;
  logic       rxstb, frmerr;

  word_state_t       wstate, wstate_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic [DATA_W-1:0] shadow, shadow_nxt;
  logic [DATA_W-1:0] wrdata_q, wrdata_nxt;
  logic              wrvalid_q, wrvalid_nxt;
  logic              rxerr_nxt;
  logic              word_done;

`ifdef RXWORD_TIMEOUT_EN
  localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_run;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .uartclk(uartclk),
    .rst    (rst),
    .rxd    (rxd),
    .rxbyte (rxbyte),
    .rxstb  (rxstb),
    .frmerr (frmerr),
    .rxbusy (rxbusy)
  );

  assign wr.wrdata  = wrdata_q;
  assign wr.wrvalid = wrvalid_q;

  // Word FSM state, shadow word and registered handshake/error outputs.
  always_ff @(posedge uartclk or posedge rst) begin
    if (rst) begin
      wstate    <= WORD_COLLECT;
      bcnt      <= '0;
      shadow    <= '0;
      wrdata_q  <= '0;
      wrvalid_q <= 1'b0;
      rxerr     <= 1'b0;
    end else begin
      wstate    <= wstate_nxt;
      bcnt      <= bcnt_nxt;
      shadow    <= shadow_nxt;
      wrdata_q  <= wrdata_nxt;
      wrvalid_q <= wrvalid_nxt;
      rxerr     <= rxerr_nxt;
    end
  end

`ifdef RXWORD_TIMEOUT_EN
  // Inter-byte timeout counter.
  always_ff @(posedge uartclk or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else     tmo_cnt <= tmo_cnt_nxt;
  end

  // Timeout only runs while a word is partially received or being resynchronised.
  assign tmo_run = (wstate != WORD_COLLECT) || (bcnt != '0);
`endif

  // Next-state: byte framing into words, publish/overrun, optional timeout.
  always_comb begin
    wstate_nxt  = wstate;
    bcnt_nxt    = bcnt;
    shadow_nxt  = shadow;
    wrdata_nxt  = wrdata_q;
    wrvalid_nxt = wrvalid_q & ~wr.wrack;
    rxerr_nxt   = frmerr;
    word_done   = 1'b0;
    if (rxstb) begin
      case (wstate)
        WORD_COLLECT: begin
          if (rxbyte == LF_CHAR) begin
            // Empty-word LF is the transmitter's trailing second LF.
            if (bcnt != '0) rxerr_nxt = 1'b1;
            bcnt_nxt = '0;
          end else begin
            shadow_nxt = {shadow[DATA_W-9:0], rxbyte};
            bcnt_nxt   = bcnt + BCNT_W'(1);
            if (bcnt == BCNT_W'(WORD_BYTES - 1)) wstate_nxt = WORD_WAIT_LF;
          end
        end
        WORD_WAIT_LF: begin
          bcnt_nxt = '0;
          if (rxbyte == LF_CHAR) begin
            word_done  = 1'b1;
            wstate_nxt = WORD_COLLECT;
          end else begin
            rxerr_nxt  = 1'b1;
            wstate_nxt = WORD_RESYNC;
          end
        end
        WORD_RESYNC: begin
          if (rxbyte == LF_CHAR) wstate_nxt = WORD_COLLECT;
        end
        default: wstate_nxt = WORD_COLLECT;
      endcase
    end
`ifdef RXWORD_TIMEOUT_EN
    tmo_cnt_nxt = '0;
    if (!rxstb && tmo_run) begin
      if (tmo_cnt == TMO_LAST) begin
        rxerr_nxt  = 1'b1;
        wstate_nxt = WORD_COLLECT;
        bcnt_nxt   = '0;
      end else begin
        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
      end
    end
`endif
    // A same-cycle ack frees the output register for the new word.
    if (word_done) begin
      if (wrvalid_q && !wr.wrack) begin
        rxerr_nxt = 1'b1;
      end else begin
        wrdata_nxt  = shadow;
        wrvalid_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word: random and directed UART traffic against a byte-queue word model.
module tb_uart_rx_word;
  import uart_rx_pkg::*;

  localparam int unsigned CPB      = 16;
  localparam int unsigned WB       = 8;
  localparam int unsigned TMO_BITS = 20;

  logic uartclk = 1'b0;
  logic rst;
  logic rxd;
  logic rxbusy;
  logic rxerr;

  uart_rx_word_if #(.WORD_BYTES(WB)) wr ();

  uart_rx_word #(
    .CLKS_PER_BIT(CPB),
    .WORD_BYTES  (WB),
    .TIMEOUT_BITS(TMO_BITS)
  ) dut (
    .uartclk(uartclk),
    .rst    (rst),
    .rxd    (rxd),
    .wr     (wr),
    .rxbusy (rxbusy),
    .rxerr  (rxerr)
  );

  always #5 uartclk = ~uartclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_seen = 0;
  int          err_exp  = 0;
  int unsigned pub_cnt  = 0;
  int unsigned ack_cnt  = 0;
  int unsigned busy_len = 0;
  int unsigned busy_rises = 0;
  bit          ack_hold = 1'b0;
  logic [63:0] exp_q[$];
  logic [7:0]  cur[$];
  bit          lost = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: words are whole LF-terminated groups of exactly WB data bytes.
  task automatic model_byte(input logic [7:0] b);
    logic [63:0] w;
    if (lost) begin
      if (b == LF_CHAR) lost = 1'b0;
    end else if (b == LF_CHAR) begin
      if (cur.size() == WB) begin
        w = '0;
        foreach (cur[i]) w = (w << 8) | 64'(cur[i]);
        if (pub_cnt != ack_cnt) err_exp++;
        else begin
          exp_q.push_back(w);
          pub_cnt++;
        end
      end else if (cur.size() != 0) begin
        err_exp++;
      end
      cur.delete();
    end else if (cur.size() == WB) begin
      err_exp++;
      lost = 1'b1;
      cur.delete();
    end else begin
      cur.push_back(b);
    end
  endtask

  task automatic model_timeout();
    if (cur.size() != 0 || lost) begin
      err_exp++;
      cur.delete();
      lost = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int unsigned n);
    rxd = 1'b1;
    repeat (n) @(negedge uartclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge uartclk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge uartclk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge uartclk);
  endtask

  task automatic send_data(input logic [7:0] b);
    model_byte(b);
    send_byte(b, 1'b1);
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == LF_CHAR) b = 8'h5A;
    return b;
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w = {w[55:0], rand_data()};
    return w;
  endfunction

  task automatic send_word(input logic [63:0] w, input bit extra_lf, input int unsigned max_gap);
    for (int i = 7; i >= 0; i--) begin
      send_data(w[8*i +: 8]);
      if (max_gap != 0) idle_cycles($urandom_range(0, max_gap));
    end
    send_data(LF_CHAR);
    if (extra_lf) send_data(LF_CHAR);
  endtask

  task automatic checkpoint(input string tag, input bit drain);
    idle_cycles(40);
    if (drain) begin
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge uartclk);
      check({tag, "_words"}, 64'(exp_q.size()), 64'd0);
    end
    check({tag, "_rxerr"}, 64'(err_seen), 64'(err_exp));
  endtask

  // Monitor: error/busy tracking, latency, wrdata vs scoreboard, consumer ack.
  initial begin : monitor
    logic        prev_busy, prev_valid, acked;
    int unsigned cyc, fall_cyc, rise_cyc, wait_n;
    prev_busy = 1'b0; prev_valid = 1'b0; acked = 1'b0;
    cyc = 0; fall_cyc = 0; rise_cyc = 0; wait_n = 0;
    wr.wrack = 1'b0;
    forever begin
      @(negedge uartclk);
      cyc++;
      wr.wrack = 1'b0;
      if (rst) begin
        prev_busy = 1'b0; prev_valid = 1'b0; acked = 1'b0;
        continue;
      end
      if (rxerr) err_seen++;
      if (!prev_busy && rxbusy) begin
        rise_cyc = cyc;
        busy_rises++;
      end
      if (prev_busy && !rxbusy) begin
        fall_cyc = cyc;
        busy_len = cyc - rise_cyc;
      end
      if (acked) check("ack_drop", 64'(wr.wrvalid), 64'd0);
      acked = 1'b0;
      if (wr.wrvalid) begin
        if (!prev_valid) check("wr_latency", 64'(cyc - fall_cyc), 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_word", wr.wrdata, 64'hX);
        end else begin
          check("wrdata", wr.wrdata, exp_q[0]);
          if (!ack_hold) begin
            if (wait_n == 0) begin
              exp_q.delete(0);
              ack_cnt++;
              wr.wrack = 1'b1;
              acked = 1'b1;
              wait_n = $urandom_range(0, 3);
            end else begin
              wait_n--;
            end
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        wr.wrack = 1'b1;
      end
      prev_busy  = rxbusy;
      prev_valid = wr.wrvalid;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned r0;
    int unsigned n;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge uartclk);
    check("rst_wrdata", wr.wrdata, 64'd0);
    check("rst_wrvalid", 64'(wr.wrvalid), 64'd0);
    check("rst_rxbusy", 64'(rxbusy), 64'd0);
    check("rst_rxerr", 64'(rxerr), 64'd0);
    rst = 1'b0;
    idle_cycles(5);

    // Directed word, double LF terminator.
    send_word(64'h0123456789ABCDEF, 1'b1, 0);
    check("byte_busy_len", 64'(busy_len), 64'(CPB / 2 + 9 * CPB));
    checkpoint("t1", 1'b1);

    // Short word, then a good one.
    send_data(8'h11); send_data(8'h22); send_data(8'h33); send_data(LF_CHAR);
    send_word(rand_word(), 1'b0, 0);
    checkpoint("t2", 1'b1);

    // Start-bit glitch shorter than half a bit.
    r0 = busy_rises;
    rxd = 1'b0;
    repeat (4) @(negedge uartclk);
    idle_cycles(2 * CPB);
    check("glitch_rises", 64'(busy_rises - r0), 64'd1);
    check("glitch_busy_len", 64'(busy_len), 64'(CPB / 2));
    check("glitch_busy_end", 64'(rxbusy), 64'd0);
    checkpoint("t3", 1'b0);

    // Framing error with rxd held low afterwards.
    send_byte(8'h55, 1'b0);
    err_exp++;
    r0 = busy_rises;
    repeat (3 * CPB) @(negedge uartclk);
    check("frm_hold_busy", 64'(rxbusy), 64'd0);
    check("frm_hold_rises", 64'(busy_rises - r0), 64'd0);
    idle_cycles(2 * CPB);
    send_word(rand_word(), 1'b0, 0);
    checkpoint("t4", 1'b1);

    // Overrun: second word arrives while the first is still unacknowledged.
    ack_hold = 1'b1;
    send_word(rand_word(), 1'b0, 0);
    send_word(rand_word(), 1'b1, 0);
    checkpoint("t5_hold", 1'b0);
    check("ovr_wrvalid", 64'(wr.wrvalid), 64'd1);
    ack_hold = 1'b0;
    checkpoint("t5", 1'b1);

    // Three bytes then a long idle gap.
    send_data(rand_data()); send_data(rand_data()); send_data(rand_data());
    idle_cycles((TMO_BITS + 2) * CPB);
`ifdef RXWORD_TIMEOUT_EN
    model_timeout();
`endif
    checkpoint("t6_gap", 1'b0);
    send_word(rand_word(), 1'b0, 0);
    send_word(rand_word(), 1'b0, 0);
    checkpoint("t6", 1'b1);

    // Random mix of good, short and over-long words with random gaps.
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(1, WB - 1);
          for (int j = 0; j < int'(n); j++) send_data(rand_data());
          send_data(LF_CHAR);
        end
        1: begin
          for (int j = 0; j < 9; j++) send_data(rand_data());
          send_data(LF_CHAR);
        end
        default: send_word(rand_word(), 1'($urandom_range(0, 1)), 2 * CPB);
      endcase
      idle_cycles($urandom_range(0, 2 * CPB));
    end
    checkpoint("rand", 1'b1);

    // Reset after a partial word: everything clears, next word is clean.
    send_data(rand_data()); send_data(rand_data()); send_data(rand_data());
    rst = 1'b1;
    @(negedge uartclk);
    check("rst2_wrdata", wr.wrdata, 64'd0);
    check("rst2_wrvalid", 64'(wr.wrvalid), 64'd0);
    check("rst2_rxbusy", 64'(rxbusy), 64'd0);
    check("rst2_rxerr", 64'(rxerr), 64'd0);
    cur.delete();
    lost = 1'b0;
    @(negedge uartclk);
    rst = 1'b0;
    idle_cycles(4);
    send_word(rand_word(), 1'b1, 0);
    checkpoint("rst2", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
